// File: rtl/mpc_issue.sv
// mpc_issue: buffers chained micro-instructions and issues them one at a time to a processor.
// Latency: ins is valid the cycle after ISSUE; res is captured into acc on WAIT exit; 1 instr / 2 cycles.
// Backpressure: host writes while full are dropped; start while busy is ignored.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   wr_en, wr_data     host push: bit18 chain flag, bits17:0 instruction (opc 17:16, A 15:8, B 7:0)
//   full, count        buffer status
//   start              one-cycle pulse that drains the buffer
//   ins                registered instruction to the processor
//   res                processor result, valid while in WAIT
//   acc                last captured result
//   busy, done         run in progress / one-cycle end-of-run pulse
module mpc_issue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [18:0]              wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     start,
  output logic [17:0]              ins,
  input  logic [8:0]               res,
  output logic [8:0]               acc,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic       chain;
    logic [1:0] opc;
    logic [7:0] a;
    logic [7:0] b;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        state, state_nxt;
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  entry_t        head;
  logic          empty, push, pop;
  logic          acc_clr, acc_cap, done_set;

  // ---------------- instruction buffer ----------------
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  // A write while full is dropped even if a pop happens in the same cycle.
  assign push  = wr_en && !full;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_t'(wr_data);
  end

  // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && !empty) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      // count already reflects the pop done in ISSUE and any earlier writes.
      S_WAIT:  state_nxt = empty ? S_IDLE : S_ISSUE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs / strobes ----------------
  always_comb begin
    busy     = 1'b0;
    pop      = 1'b0;
    acc_clr  = 1'b0;
    acc_cap  = 1'b0;
    done_set = 1'b0;
    case (state)
      S_IDLE: begin
        acc_clr  = start;
        done_set = start && empty;
      end
      S_ISSUE: begin
        busy = 1'b1;
        pop  = 1'b1;
      end
      S_WAIT: begin
        busy     = 1'b1;
        acc_cap  = 1'b1;
        done_set = empty;
      end
      default: ;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins  <= '0;
      acc  <= '0;
      done <= 1'b0;
    end else begin
      done <= done_set;
      // Chained entries take operand A from the low byte of the previous result.
      if (pop) ins <= head.chain ? {head.opc, acc[7:0], head.b} : {head.opc, head.a, head.b};
      if (acc_clr)      acc <= '0;
      else if (acc_cap) acc <= res;
    end
  end

endmodule

// File: tb/tb_mpc_issue.sv
module tb_mpc_issue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [18:0] wr_data = '0;
  logic        full;
  logic [2:0]  count;
  logic        start = 1'b0;
  logic [17:0] ins;
  logic [8:0]  res;
  logic [8:0]  acc;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  mpc_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .count(count), .start(start), .ins(ins), .res(res),
    .acc(acc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Processor result rule: B or constant 1 as operand; add or subtract, 9-bit wrap.
  function automatic logic [8:0] alu(input logic [17:0] i);
    logic [8:0] a, op;
    a  = {1'b0, i[15:8]};
    op = i[16] ? {1'b0, i[7:0]} : 9'd1;
    return i[17] ? (a + op) : (a - op);
  endfunction

  // The bench plays the processor.
  always_comb res = alu(ins);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A run is a sequence of two-cycle slots (issue, then wait) over a queue of entries.
  logic [18:0] q[$];
  bit          m_run = 0;
  bit          m_issue_slot = 0;
  logic [17:0] m_ins = '0;
  logic [8:0]  m_acc = '0;
  bit          m_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_run = 0; m_issue_slot = 0; m_ins = '0; m_acc = '0; m_done = 0;
    end else begin
      bit          was_full, nd;
      logic [18:0] e;
      was_full = (q.size() == DEPTH);
      nd = 0;
      if (!m_run) begin
        if (start) begin
          m_acc = '0;
          if (q.size() > 0) begin m_run = 1; m_issue_slot = 1; end
          else nd = 1;
        end
      end else if (m_issue_slot) begin
        e = q.pop_front();
        m_ins = e[18] ? {e[17:16], m_acc[7:0], e[7:0]} : e[17:0];
        m_issue_slot = 0;
      end else begin
        m_acc = alu(m_ins);
        if (q.size() > 0) m_issue_slot = 1;
        else begin m_run = 0; nd = 1; end
      end
      if (wr_en && !was_full) q.push_back(wr_data);
      m_done = nd;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("count", count, q.size());
    chk("full",  full,  (q.size() == DEPTH));
    chk("busy",  busy,  m_run);
    chk("done",  done,  m_done);
    chk("ins",   ins,   m_ins);
    chk("acc",   acc,   m_acc);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [18:0] d);
    wr_en = 1'b1; wr_data = d; cyc(); wr_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    bit seen;
    cyc(); cyc();
    chk("rst_ins", ins, 0); chk("rst_acc", acc, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_count", count, 0); chk("rst_full", full, 0);
    rst_n = 1'b1;
    cyc();

    // Single plain add using B.
    push({1'b0, 18'h30503});
    chk("t1_count", count, 1);
    go();
    chk("t1_busy_issue", busy, 1); chk("t1_ins_hold", ins, 0);
    cyc();
    chk("t1_ins", ins, 18'h30503); chk("t1_done_early", done, 0);
    cyc();
    chk("t1_acc", acc, 9'h008); chk("t1_done", done, 1); chk("t1_busy_end", busy, 0);
    cyc();
    chk("t1_done_pulse", done, 0);

    // Subtract with 9-bit borrow wrap; ins holds between runs.
    push({1'b0, 18'h10305});
    go();
    chk("t2_ins_hold", ins, 18'h30503);
    cyc();
    chk("t2_ins", ins, 18'h10305);
    cyc();
    chk("t2_acc", acc, 9'h1fe); chk("t2_done", done, 1);
    cyc();

    // Chained second entry takes A from acc[7:0].
    push({1'b0, 18'h30503});
    push({1'b1, 18'h2ff00});
    go(); cyc(); cyc();
    chk("t3_acc_mid", acc, 9'h008); chk("t3_busy_mid", busy, 1);
    cyc();
    chk("t3_ins2", ins, 18'h20800);
    cyc();
    chk("t3_acc", acc, 9'h009); chk("t3_done", done, 1);
    cyc();

    // Fill to DEPTH; the fifth write is dropped.
    push({1'b0, 18'h30101});
    push({1'b0, 18'h10503});
    push({1'b0, 18'h00901});
    push({1'b0, 18'h20a00});
    chk("t4_full", full, 1); chk("t4_count4", count, 4);
    push({1'b0, 18'h3ffff});
    chk("t4_count_drop", count, 4);
    go();
    nb = 0; seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (busy) nb++;
      if (done) seen = 1;
      else cyc();
    end
    chk("t4_done_seen", seen, 1);
    chk("t4_busy_cycles", nb, 8);
    chk("t4_acc", acc, 9'h00b); chk("t4_count_end", count, 0);
    cyc();

    // Start with empty buffer.
    go();
    chk("t5_busy", busy, 0); chk("t5_done", done, 1); chk("t5_acc", acc, 0);
    cyc();
    chk("t5_done_pulse", done, 0);

    // Write during ISSUE (push + pop same cycle), issued in the same run.
    push({1'b0, 18'h30101});
    go();
    wr_en = 1'b1; wr_data = {1'b1, 18'h30004};
    cyc();
    wr_en = 1'b0;
    chk("t6_count_pushpop", count, 1);
    cyc();
    chk("t6_busy_second", busy, 1);
    cyc();
    chk("t6_ins2", ins, 18'h30204);
    cyc();
    chk("t6_acc", acc, 9'h006); chk("t6_done", done, 1);
    cyc();

    // Reset during WAIT of entry 2 of 3.
    push({1'b0, 18'h30101});
    push({1'b0, 18'h30202});
    push({1'b0, 18'h30303});
    go(); cyc(); cyc(); cyc();
    chk("t7_pre_count", count, 1); chk("t7_pre_ins", ins, 18'h30202);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_ins", ins, 0); chk("t7_acc", acc, 0); chk("t7_busy", busy, 0);
    chk("t7_done", done, 0); chk("t7_count", count, 0); chk("t7_full", full, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t7_no_done", done, 0);
    cyc();
    go();
    chk("t7_busy_after", busy, 0); chk("t7_done_after", done, 1); chk("t7_acc_after", acc, 0);
    cyc();
    chk("t7_done_pulse", done, 0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mpc_issue.md
MPC_ISSUE -- requirements
Module: mpc_issue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of instruction buffer entries; legal values are 2, 4, 8 and 16.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 wr_en  input  1  SHALL be the host write strobe that pushes wr_data into the buffer.
REQ-005 wr_data  input  19  SHALL carry bit18 = chain flag and bits17:0 = instruction word (opcode 17:16, A 15:8, B 7:0).
REQ-006 full  output  1  SHALL be high when the buffer holds DEPTH entries.
REQ-007 count  output  clog2(DEPTH)+1  SHALL give the number of buffered entries.
REQ-008 start  input  1  SHALL be the single-cycle pulse that begins draining the buffer.
REQ-009 ins  output  18  SHALL be the registered instruction word driven to the processor.
REQ-010 res  input  9  SHALL be the processor's registered result, valid one cycle after ins changes.
REQ-011 acc  output  9  SHALL hold the last captured result.
REQ-012 busy  output  1  SHALL be high in ISSUE and WAIT.
REQ-013 done  output  1  SHALL be a one-cycle pulse marking the end of a run.

Function
REQ-014 The buffer SHALL be a FIFO with DEPTH entries; the pointers wrap modulo DEPTH.
REQ-015 wr_en with full=1 SHALL be ignored, leaving contents and count unchanged.
REQ-016 wr_en and pop in the same cycle while not full SHALL both occur, leaving count unchanged.
REQ-017 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT.
REQ-018 IDLE + start: acc SHALL be cleared to 0; if count>0 the FSM SHALL go to ISSUE, else it SHALL stay in IDLE and pulse done in the next cycle.
REQ-019 ISSUE SHALL pop the head entry, load ins and go to WAIT; the entry is one cycle in ISSUE and one in WAIT.
REQ-020 When loading ins, a chain flag of 1 SHALL replace ins[15:8] with acc[7:0], while ins[17:16] and ins[7:0] come from the entry.
REQ-021 A chain flag of 0 SHALL load ins with wr_data[17:0] unmodified.
REQ-022 On exiting WAIT, res SHALL be captured into acc.
REQ-023 On exiting WAIT, the FSM SHALL go to ISSUE if count>0, else to IDLE.
REQ-024 done SHALL pulse in the cycle after the final WAIT.
REQ-025 Writes during a run SHALL be accepted; an entry written before the WAIT-exit count check SHALL be issued in the same run.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 Between issues, ins SHALL hold its last value.
REQ-028 Throughput SHALL be one instruction per 2 cycles.
REQ-029 The result model is: ins[16]=1 selects operand B, else the constant 1.
REQ-030 In that model, ins[17]=1 gives A+operand, else A-operand, as a 9-bit result.
REQ-031 A 9-bit borrow wrap (e.g. 0x1FE) SHALL be stored as-is; chaining SHALL use only acc[7:0].

Reset
REQ-032 rst_n low SHALL immediately force: state IDLE, ins=0, acc=0, done=0, busy=0, count=0, full=0, FIFO pointers 0.
REQ-033 Reset mid-run SHALL discard all buffered entries, with no done pulse.
REQ-034 After rst_n rises, operation SHALL resume on the first rising clk edge with rst_n high.

Verification
REQ-035 Write {0,18'h30503}, start -> ins=18'h30503 in ISSUE+1; res=9'h008 presented -> acc=9'h008; done pulses 2 cycles after ISSUE entry.
REQ-036 Write {0,18'h10305}, start -> 0x03-0x05 -> acc=9'h1FE.
REQ-037 Write {0,18'h30503} then {1,18'h2FF00}, start -> second ins=18'h20800 -> acc=9'h009.
REQ-038 Write 5 entries with DEPTH=4 -> full=1 after 4; 5th dropped; start -> exactly 4 issues, 8 busy cycles, then done.
REQ-039 start with count=0 -> busy stays 0, done pulses the next cycle, acc=0.
REQ-040 rst_n low during WAIT of entry 2 of 3 -> all outputs 0 immediately, count=0, no done pulse; after release, a new start with an empty buffer behaves as REQ-039.
